// File: rtl/tdc_meas_seq_if.sv
// Result handshake between the TDC measurement sequencer (master) and its consumer (slave).
interface tdc_meas_seq_if #(
    parameter int CH_W   = 1,
    parameter int DATA_W = 9
);
    logic              res_valid;
    logic              res_ready;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;

    modport master (output res_valid, res_ch, res_data, input res_ready);
    modport slave  (input res_valid, res_ch, res_data, output res_ready);
endinterface

// File: rtl/tdc_meas_seq.sv
// Multi-channel TDC measurement sequencer: launches 2**ACC_LOG2 pulses per enabled channel,
// converts each thermometer tap word to a leading-ones count and returns the per-channel sum.
module tdc_meas_seq #(
    parameter int N_CH      = 2,
    parameter int DL_LEN    = 32,
    parameter int CNT_W     = $clog2(DL_LEN + 1),
    parameter int ACC_LOG2  = 3,
    parameter int TOG_DIV_W = 8,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_pls_src,
    input  logic                   cfg_bypass,
    input  logic [N_CH-1:0]        cfg_ch_en,
    input  logic [TOG_DIV_W-1:0]   cfg_tog_div,
    input  logic                   start,
    input  logic                   pg_in,
    input  logic [N_CH*DL_LEN-1:0] dl_tap_i,
    output logic [N_CH-1:0]        launch_o,
    output logic                   busy,
    output logic                   done,
    output logic                   err_bubble,
    tdc_meas_seq_if.master         res_if
);
    localparam int ACC_W = CNT_W + ACC_LOG2;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_LAUNCH, S_SETTLE, S_SAMPLE, S_OUT} state_e;

    state_e                state_q, state_d;
    logic                  src_q, src_d, byp_q, byp_d;
    logic [N_CH-1:0]       en_q, en_d;
    logic [TOG_DIV_W-1:0]  div_cfg_q, div_cfg_d, div_cnt_q, div_cnt_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_LOG2-1:0]   smp_q, smp_d;
    logic [DL_LEN-1:0]     tap_q, tap_d;
    logic [N_CH-1:0]       launch_q, launch_d;
    logic                  done_q, done_d, err_q, err_d, pg_prev_q;

    logic [CH_W-1:0]       first_ch, next_ch;
    logic                  next_ok, seen_zero, bubble, arm_go;
    logic [DL_LEN-1:0]     tap_sel, smp_word;
    logic [CNT_W-1:0]      cnt;

    // Channel search, tap selection and thermometer-to-count conversion.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        first_ch  = '0;
        next_ch   = '0;
        next_ok   = 1'b0;
        tap_sel   = '0;
        cnt       = '0;
        seen_zero = 1'b0;
        bubble    = 1'b0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (cfg_ch_en[c]) first_ch = CH_W'(c);
            if (en_q[c] && (c > int'(ch_q))) begin
                next_ch = CH_W'(c);
                next_ok = 1'b1;
            end
            if (CH_W'(c) == ch_q) tap_sel = dl_tap_i[c*DL_LEN +: DL_LEN];
        end
        smp_word = byp_q ? tap_q : tap_sel;
        // Count stops at the first 0; any 1 beyond it is a bubble.
        for (int i = 0; i < DL_LEN; i++) begin
            if (!smp_word[i])   seen_zero = 1'b1;
            else if (seen_zero) bubble    = 1'b1;
            else                cnt       = cnt + CNT_W'(1);
        end
        arm_go = src_q ? (div_cnt_q == div_cfg_q) : (pg_in && !pg_prev_q);
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        byp_d     = byp_q;
        en_d      = en_q;
        div_cfg_d = div_cfg_q;
        div_cnt_d = '0;
        ch_d      = ch_q;
        acc_d     = acc_q;
        smp_d     = smp_q;
        tap_d     = tap_q;
        err_d     = err_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: if (start && (cfg_ch_en != '0)) begin
                src_d     = cfg_pls_src;
                byp_d     = cfg_bypass;
                en_d      = cfg_ch_en;
                div_cfg_d = cfg_tog_div;
                ch_d      = first_ch;
                acc_d     = '0;
                smp_d     = '0;
                err_d     = 1'b0;
                state_d   = S_ARM;
            end
            S_ARM: begin
                if (arm_go) state_d   = S_LAUNCH;
                else        div_cnt_d = div_cnt_q + TOG_DIV_W'(1);
            end
            S_LAUNCH: state_d = byp_q ? S_SETTLE : S_SAMPLE;
            S_SETTLE: begin
                tap_d   = tap_sel;
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                acc_d = acc_q + ACC_W'(cnt);
                err_d = err_q | bubble;
                if (smp_q == '1) begin
                    state_d = S_OUT;
                end else begin
                    smp_d   = smp_q + ACC_LOG2'(1);
                    state_d = S_ARM;
                end
            end
            S_OUT: if (res_if.res_ready) begin
                if (next_ok) begin
                    ch_d    = next_ch;
                    acc_d   = '0;
                    smp_d   = '0;
                    state_d = S_ARM;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Launch is registered: it rises together with the LAUNCH state and lasts one cycle.
        for (int c = 0; c < N_CH; c++) launch_d[c] = (state_d == S_LAUNCH) && (CH_W'(c) == ch_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_q     <= 1'b0;
            byp_q     <= 1'b0;
            en_q      <= '0;
            div_cfg_q <= '0;
            div_cnt_q <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            smp_q     <= '0;
            tap_q     <= '0;
            launch_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pg_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            byp_q     <= byp_d;
            en_q      <= en_d;
            div_cfg_q <= div_cfg_d;
            div_cnt_q <= div_cnt_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            smp_q     <= smp_d;
            tap_q     <= tap_d;
            launch_q  <= launch_d;
            done_q    <= done_d;
            err_q     <= err_d;
            pg_prev_q <= pg_in;
        end
    end

    assign launch_o         = launch_q;
    assign done             = done_q;
    assign err_bubble       = err_q;
    assign busy             = (state_q != S_IDLE);
    assign res_if.res_valid = (state_q == S_OUT);
    assign res_if.res_ch    = ch_q;
    assign res_if.res_data  = acc_q;
endmodule
